excp_ctrl: RTL

//  Exception sequencer for the multicycle MIPS datapath; owns the memory-address mux select (iord) and its

---
 rtl/excp_ctrl_pkg.sv | 27 ++
 rtl/excp_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/excp_ctrl_pkg.sv
// rtl/excp_ctrl_pkg.sv - shared encodings for the exception sequencer
package excp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SAVE = 2'b01,
    ST_WAIT = 2'b10,
    ST_LOAD = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIVZERO  = 2'b11
  } cause_t;

  localparam logic [1:0] IORD_PC        = 2'b00;
  localparam logic [1:0] IORD_ULARESULT = 2'b01;
  localparam logic [1:0] IORD_ULAOUT    = 2'b10;
  localparam logic [1:0] IORD_EXCP      = 2'b11;

  localparam logic [31:0] DEF_VEC_OPCODE   = 32'd253;
  localparam logic [31:0] DEF_VEC_OVERFLOW = 32'd254;
  localparam logic [31:0] DEF_VEC_DIVZERO  = 32'd255;

endpackage

// File: rtl/excp_ctrl.sv
// rtl/excp_ctrl.sv - exception sequencer for the multicycle MIPS datapath
// Saves EPC, fetches the handler byte from the vector address, then loads it into PC.
module excp_ctrl
  import excp_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE   = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVERFLOW = DEF_VEC_OVERFLOW,
  parameter logic [31:0] VEC_DIVZERO  = DEF_VEC_DIVZERO,
  parameter int          MEM_LATENCY  = 1,
  parameter logic [31:0] EPC_OFFSET   = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  ctrl_iord_sel,
  input  logic        ctrl_mem_wr,
  input  logic        excp_opcode,
  input  logic        excp_overflow,
  input  logic        excp_divzero,
  input  logic [31:0] PC_current,
  input  logic [31:0] mem_data_out,
  output logic [1:0]  iord_selector,
  output logic [31:0] excpCtrl_output,
  output logic        mem_wr,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic [1:0]  excp_cause,
  output logic        busy
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [CW-1:0] r_cnt;
  cause_t      r_cause;
  cause_t      w_cause;
  logic [31:0] r_vector;
  logic [31:0] w_vector;
  logic [31:0] r_epc;
  logic        w_excp_any;
  logic        w_unused_mem;

  assign w_excp_any   = excp_opcode | excp_overflow | excp_divzero;
  assign w_unused_mem = ^mem_data_out[31:8];
  assign epc_data     = r_epc;
  assign excp_cause   = r_cause;

  always_comb begin
    w_cause  = CAUSE_NONE;
    w_vector = '0;
    if (excp_opcode) begin
      w_cause  = CAUSE_OPCODE;
      w_vector = VEC_OPCODE;
    end else if (excp_overflow) begin
      w_cause  = CAUSE_OVERFLOW;
      w_vector = VEC_OVERFLOW;
    end else if (excp_divzero) begin
      w_cause  = CAUSE_DIVZERO;
      w_vector = VEC_DIVZERO;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_cause  <= CAUSE_NONE;
      r_vector <= '0;
      r_epc    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_excp_any) begin
        r_cause  <= w_cause;
        r_vector <= w_vector;
        r_epc    <= PC_current - EPC_OFFSET;
      end
      // WAIT dwell is CNT_INIT+1 cycles, counted down from the SAVE cycle
      if (r_state == ST_SAVE) begin
        r_cnt <= CNT_INIT;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    iord_selector   = ctrl_iord_sel;
    excpCtrl_output = '0;
    mem_wr          = ctrl_mem_wr;
    epc_wr          = 1'b0;
    pc_wr           = 1'b0;
    pc_data         = '0;
    busy            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_excp_any) w_next_state = ST_SAVE;
      end
      ST_SAVE: begin
        epc_wr          = 1'b1;
        iord_selector   = IORD_EXCP;
        excpCtrl_output = r_vector;
        mem_wr          = 1'b0;
        busy            = 1'b1;
        w_next_state    = ST_WAIT;
      end
      ST_WAIT: begin
        iord_selector   = IORD_EXCP;
        excpCtrl_output = r_vector;
        mem_wr          = 1'b0;
        busy            = 1'b1;
        if (r_cnt == '0) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        pc_wr           = 1'b1;
        pc_data         = {24'b0, mem_data_out[7:0]};
        iord_selector   = IORD_EXCP;
        excpCtrl_output = r_vector;
        mem_wr          = 1'b0;
        busy            = 1'b1;
        w_next_state    = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule
